// File: rtl/layer_seq_pkg.sv
// Shared types and helpers for the layer sequencer: FSM state encoding,
// instance position width and slot/sprite sizing helpers.
package layer_seq_pkg;

   localparam int POS_W = 10;

   localparam int DEF_NUM_LAYERS  = 3;
   localparam int DEF_MAX_INST    = 8;
   localparam int DEF_SPRITE_SIZE = 32;

   typedef enum logic [2:0] {
      IDLE,
      BG,
      SETUP,
      DRAW,
      DONE
   } state_t;

   function automatic int slot_num(input int num_layers, input int max_inst);
      return num_layers * max_inst;
   endfunction

   function automatic int spr_bits(input int sprite_size);
      return $clog2(sprite_size);
   endfunction

endpackage

// File: rtl/layer_sequencer_rect_walker.sv
// Raster-order walker over a W x H rectangle. start_i rewinds to (0,0),
// adv_i steps one pixel; done_o flags the last pixel of the rectangle.
module rect_walker #(
   parameter int W  = 320,
   parameter int H  = 180,
   parameter int XW = (W > 1) ? $clog2(W) : 1,
   parameter int YW = (H > 1) ? $clog2(H) : 1
) (
   input  logic          clk_i,
   input  logic          rst_n_i,
   input  logic          start_i,
   input  logic          adv_i,
   output logic [XW-1:0] x_o,
   output logic [YW-1:0] y_o,
   output logic          done_o
);

   logic [XW-1:0] x_q, x_d;
   logic [YW-1:0] y_q, y_d;
   logic          x_end, y_end;

   assign x_end  = (x_q == XW'(W - 1));
   assign y_end  = (y_q == YW'(H - 1));
   assign done_o = x_end && y_end;
   assign x_o    = x_q;
   assign y_o    = y_q;

   always_comb begin
      x_d = x_q;
      y_d = y_q;
      if (start_i) begin
         x_d = '0;
         y_d = '0;
      end else if (adv_i) begin
         if (x_end) begin
            x_d = '0;
            y_d = y_end ? '0 : y_q + 1'b1;
         end else begin
            x_d = x_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         x_q <= '0;
         y_q <= '0;
      end else begin
         x_q <= x_d;
         y_q <= y_d;
      end
   end

endmodule

// File: rtl/layer_sequencer.sv
// Frame composer: tiled background, then NUM_LAYERS x MAX_INST clipped sprites,
// with VRAM back-pressure. Define LAYER_SEQ_OVERRUN_CNT_EN to add o_overrun_cnt.
module layer_sequencer
   import layer_seq_pkg::*;
#(
   parameter int VRAM_A_WIDTH      = 16,
   parameter int SPRITEBUF_A_WIDTH = 14,
   parameter int SCREEN_WIDTH      = 320,
   parameter int SCREEN_HEIGHT     = 180,
   parameter int SPRITE_SIZE       = DEF_SPRITE_SIZE,
   parameter int NUM_LAYERS        = DEF_NUM_LAYERS,
   parameter int MAX_INST          = DEF_MAX_INST,
   parameter int BG_OFFSET         = 0,
   parameter logic [NUM_LAYERS*SPRITEBUF_A_WIDTH-1:0] LAYER_OFFSETS = '0
) (
   input  logic                                   CLK,
   input  logic                                   rst_n,
   input  logic                                   i_frame_start,
   input  logic [POS_W*NUM_LAYERS*MAX_INST-1:0]   i_pos_x,
   input  logic [POS_W*NUM_LAYERS*MAX_INST-1:0]   i_pos_y,
   input  logic [NUM_LAYERS*MAX_INST-1:0]         i_inst_valid,
   input  logic                                   i_ready,
`ifdef LAYER_SEQ_OVERRUN_CNT_EN
   output logic [7:0]                             o_overrun_cnt,
`endif
   output logic [VRAM_A_WIDTH-1:0]                o_address_screen,
   output logic [SPRITEBUF_A_WIDTH-1:0]           o_address_s,
   output logic                                   o_we,
   output logic                                   o_busy,
   output logic                                   o_frame_done,
   output logic [3:0]                             o_layer_idx,
   output logic [3:0]                             o_inst_idx
);

   localparam int SLOT_NUM = slot_num(NUM_LAYERS, MAX_INST);
   localparam int SPR_BITS = spr_bits(SPRITE_SIZE);
   localparam int XW       = $clog2(SCREEN_WIDTH);
   localparam int YW       = $clog2(SCREEN_HEIGHT);

   state_t                     state_q, state_d;
   logic [3:0]                 layer_q, layer_d, inst_q, inst_d;
   logic [POS_W*SLOT_NUM-1:0]  pos_x_q, pos_y_q;
   logic [SLOT_NUM-1:0]        valid_q;

   logic                bg_start, bg_adv, bg_done;
   logic [XW-1:0]       bg_x;
   logic [YW-1:0]       bg_y;
   logic                sp_start, sp_adv, sp_done;
   logic [SPR_BITS-1:0] sp_x, sp_y;

   int                  slot_idx;
   logic                last_slot, clipped;
   logic [10:0]         scr_x, scr_y;

   rect_walker #(.W(SCREEN_WIDTH), .H(SCREEN_HEIGHT), .XW(XW), .YW(YW)) u_bg_walk (
      .clk_i(CLK), .rst_n_i(rst_n), .start_i(bg_start), .adv_i(bg_adv),
      .x_o(bg_x), .y_o(bg_y), .done_o(bg_done)
   );

   rect_walker #(.W(SPRITE_SIZE), .H(SPRITE_SIZE), .XW(SPR_BITS), .YW(SPR_BITS)) u_spr_walk (
      .clk_i(CLK), .rst_n_i(rst_n), .start_i(sp_start), .adv_i(sp_adv),
      .x_o(sp_x), .y_o(sp_y), .done_o(sp_done)
   );

   // 11-bit sums so that positions near 1023 clip instead of wrapping on screen.
   always_comb begin
      slot_idx  = int'(layer_q) * MAX_INST + int'(inst_q);
      last_slot = (layer_q == 4'(NUM_LAYERS - 1)) && (inst_q == 4'(MAX_INST - 1));
      scr_x     = {1'b0, pos_x_q[slot_idx*POS_W +: POS_W]} + 11'(sp_x);
      scr_y     = {1'b0, pos_y_q[slot_idx*POS_W +: POS_W]} + 11'(sp_y);
      clipped   = (scr_x >= 11'(SCREEN_WIDTH)) || (scr_y >= 11'(SCREEN_HEIGHT));
   end

   always_ff @(posedge CLK) begin
      if (!rst_n) begin
         state_q <= IDLE;
         layer_q <= '0;
         inst_q  <= '0;
      end else begin
         state_q <= state_d;
         layer_q <= layer_d;
         inst_q  <= inst_d;
      end
   end

   always_ff @(posedge CLK) begin
      if (!rst_n) begin
         pos_x_q <= '0;
         pos_y_q <= '0;
         valid_q <= '0;
      end else if (i_frame_start) begin
         pos_x_q <= i_pos_x;
         pos_y_q <= i_pos_y;
         valid_q <= i_inst_valid;
      end
   end

   always_comb begin
      state_d  = state_q;
      layer_d  = layer_q;
      inst_d   = inst_q;
      bg_start = 1'b0;
      bg_adv   = 1'b0;
      sp_start = 1'b0;
      sp_adv   = 1'b0;
      if (i_frame_start) begin
         state_d  = BG;
         layer_d  = '0;
         inst_d   = '0;
         bg_start = 1'b1;
      end else begin
         case (state_q)
            BG: begin
               if (i_ready) begin
                  bg_adv = 1'b1;
                  if (bg_done) state_d = SETUP;
               end
            end
            SETUP, DRAW: begin
               if (state_q == SETUP && valid_q[slot_idx]) begin
                  state_d  = DRAW;
                  sp_start = 1'b1;
               end else if (state_q == SETUP || clipped || i_ready) begin
                  sp_adv = (state_q == DRAW);
                  if (state_q == SETUP || sp_done) begin
                     if (last_slot) begin
                        state_d = DONE;
                     end else begin
                        state_d = SETUP;
                        if (inst_q == 4'(MAX_INST - 1)) begin
                           inst_d  = '0;
                           layer_d = layer_q + 1'b1;
                        end else begin
                           inst_d = inst_q + 1'b1;
                        end
                     end
                  end
               end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
         endcase
      end
   end

   always_comb begin
      o_busy           = (state_q != IDLE);
      o_frame_done     = (state_q == DONE);
      o_we             = 1'b0;
      o_layer_idx      = '0;
      o_inst_idx       = '0;
      o_address_screen = '0;
      o_address_s      = '0;
      case (state_q)
         BG: begin
            o_we             = 1'b1;
            o_address_screen = VRAM_A_WIDTH'(32'(bg_y) * 32'(SCREEN_WIDTH) + 32'(bg_x));
            o_address_s      = SPRITEBUF_A_WIDTH'(BG_OFFSET)
                               + SPRITEBUF_A_WIDTH'({bg_y[SPR_BITS-1:0], bg_x[SPR_BITS-1:0]});
         end
         SETUP: begin
            o_layer_idx = layer_q + 1'b1;
            o_inst_idx  = inst_q;
         end
         DRAW: begin
            o_we             = !clipped;
            o_layer_idx      = layer_q + 1'b1;
            o_inst_idx       = inst_q;
            o_address_screen = VRAM_A_WIDTH'(32'(scr_y) * 32'(SCREEN_WIDTH) + 32'(scr_x));
            o_address_s      = LAYER_OFFSETS[int'(layer_q)*SPRITEBUF_A_WIDTH +: SPRITEBUF_A_WIDTH]
                               + SPRITEBUF_A_WIDTH'({sp_y, sp_x});
         end
         default: ;
      endcase
   end

`ifdef LAYER_SEQ_OVERRUN_CNT_EN
   logic [7:0] ovr_q, ovr_d;

   always_comb begin
      ovr_d = ovr_q;
      if (i_frame_start && state_q != IDLE && ovr_q != 8'hFF) ovr_d = ovr_q + 1'b1;
   end

   always_ff @(posedge CLK) begin
      if (!rst_n) ovr_q <= '0;
      else        ovr_q <= ovr_d;
   end

   assign o_overrun_cnt = ovr_q;
`endif

endmodule

// File: tb/tb_layer_sequencer.sv
// Bench for layer_sequencer on an 8x4 screen, 4x4 sprites, 2 layers x 2 slots.
// Expected pixel streams come from a frame-level model of the drawing rules.
module tb_layer_sequencer;

   localparam int SW = 8;
   localparam int SH = 4;
   localparam int SS = 4;
   localparam int NL = 2;
   localparam int MI = 2;
   localparam int NS = NL * MI;
   localparam logic [27:0] LOFF = {14'd32, 14'd16};

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             frame_start = 1'b0;
   logic             ready = 1'b1;
   logic [10*NS-1:0] pos_x = '0;
   logic [10*NS-1:0] pos_y = '0;
   logic [NS-1:0]    inst_valid = '0;
   logic [15:0]      o_address_screen;
   logic [13:0]      o_address_s;
   logic             o_we, o_busy, o_frame_done;
   logic [3:0]       o_layer_idx, o_inst_idx;
`ifdef LAYER_SEQ_OVERRUN_CNT_EN
   logic [7:0]       o_overrun_cnt;
`endif

   int               n_tests = 0;
   int               n_fail  = 0;
   int               exp_ovr = 0;
   int               exp_cycles;
   int               layer_off [NL] = '{16, 32};
   logic [37:0]      exp_q [$];
   bit               aborted;

   layer_sequencer #(
      .VRAM_A_WIDTH(16), .SPRITEBUF_A_WIDTH(14), .SCREEN_WIDTH(SW), .SCREEN_HEIGHT(SH),
      .SPRITE_SIZE(SS), .NUM_LAYERS(NL), .MAX_INST(MI), .BG_OFFSET(0), .LAYER_OFFSETS(LOFF)
   ) dut (
      .CLK(clk), .rst_n(rst_n), .i_frame_start(frame_start),
      .i_pos_x(pos_x), .i_pos_y(pos_y), .i_inst_valid(inst_valid), .i_ready(ready),
`ifdef LAYER_SEQ_OVERRUN_CNT_EN
      .o_overrun_cnt(o_overrun_cnt),
`endif
      .o_address_screen(o_address_screen), .o_address_s(o_address_s), .o_we(o_we),
      .o_busy(o_busy), .o_frame_done(o_frame_done),
      .o_layer_idx(o_layer_idx), .o_inst_idx(o_inst_idx)
   );

   // clock / reset
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [39:0] obs, input logic [39:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Frame-level model: list of expected writes {layer, inst, screen, sprite}.
   task automatic build_expected();
      int nvalid = 0;
      exp_q.delete();
      for (int y = 0; y < SH; y++)
         for (int x = 0; x < SW; x++)
            exp_q.push_back({4'd0, 4'd0, 16'(y*SW + x), 14'((y%SS)*SS + (x%SS))});
      for (int k = 0; k < NL; k++)
         for (int i = 0; i < MI; i++) begin
            int s = k*MI + i;
            if (inst_valid[s]) begin
               int px = int'(pos_x[10*s +: 10]);
               int py = int'(pos_y[10*s +: 10]);
               nvalid++;
               for (int sy = 0; sy < SS; sy++)
                  for (int sx = 0; sx < SS; sx++)
                     if (px+sx < SW && py+sy < SH)
                        exp_q.push_back({4'(k+1), 4'(i), 16'((py+sy)*SW + px+sx),
                                         14'(layer_off[k] + sy*SS + sx)});
            end
         end
      exp_cycles = SW*SH + NS + nvalid*SS*SS + 1;
   endtask

   task automatic set_slot(input int s, input int x, input int y, input bit v);
      pos_x[10*s +: 10] = 10'(x);
      pos_y[10*s +: 10] = 10'(y);
      inst_valid[s]     = v;
   endtask

   task automatic randomize_slots();
      for (int s = 0; s < NS; s++) begin
         int x = ($urandom_range(0, 3) == 0) ? 1020 + $urandom_range(0, 3) : $urandom_range(0, 10);
         int y = ($urandom_range(0, 3) == 0) ? 1020 + $urandom_range(0, 3) : $urandom_range(0, 6);
         set_slot(s, x, y, 1'($urandom_range(0, 1)));
      end
   endtask

   // Driver + monitor for one frame; called and returns at a negedge.
   task automatic run_frame(input int abort_at, input int ready_pct, input int stall_at,
                            output bit was_aborted);
      int  stalls = 0;
      int  writes = 0;
      int  hold   = 0;
      bit  got_done = 0;
      build_expected();
      was_aborted = 0;
      frame_start = 1'b1;
      for (int n = 1; n <= 4000 && !got_done && !was_aborted; n++) begin
         @(negedge clk);
         frame_start = 1'b0;
         if (o_frame_done) begin
            got_done = 1;
            check("done_latency", 40'(n), 40'(exp_cycles + stalls));
         end else if (abort_at >= 0 && writes >= abort_at && o_layer_idx != 0 && o_we) begin
            was_aborted = 1;
         end else begin
            check("busy", 40'(o_busy), 40'd1);
            if (writes == stall_at && hold < 5) begin
               ready = 1'b0;
               hold++;
            end else begin
               ready = ($urandom_range(0, 99) < ready_pct);
            end
            if (o_we) begin
               if (exp_q.size() == 0) begin
                  check("extra_write", 40'd1, 40'd0);
               end else begin
                  check("pixel", 40'({o_layer_idx, o_inst_idx, o_address_screen, o_address_s}),
                        40'(exp_q[0]));
                  if (ready) begin
                     void'(exp_q.pop_front());
                     writes++;
                  end else begin
                     stalls++;
                  end
               end
            end
         end
      end
      if (!was_aborted) begin
         check("frame_done_seen", 40'(got_done), 40'd1);
         check("all_pixels_written", 40'(exp_q.size()), 40'd0);
         ready = 1'b1;
         @(negedge clk);
         check("done_one_cycle", 40'(o_frame_done), 40'd0);
         check("busy_after_done", 40'(o_busy), 40'd0);
`ifdef LAYER_SEQ_OVERRUN_CNT_EN
         check("overrun_cnt", 40'(o_overrun_cnt), 40'(exp_ovr));
`endif
      end
   endtask

   task automatic check_idle_outputs(input string tag);
      check({tag, "_we"}, 40'(o_we), 40'd0);
      check({tag, "_busy"}, 40'(o_busy), 40'd0);
      check({tag, "_done"}, 40'(o_frame_done), 40'd0);
      check({tag, "_addr_screen"}, 40'(o_address_screen), 40'd0);
      check({tag, "_addr_s"}, 40'(o_address_s), 40'd0);
      check({tag, "_layer"}, 40'(o_layer_idx), 40'd0);
      check({tag, "_inst"}, 40'(o_inst_idx), 40'd0);
`ifdef LAYER_SEQ_OVERRUN_CNT_EN
      check({tag, "_ovr"}, 40'(o_overrun_cnt), 40'd0);
`endif
   endtask

   initial begin
      repeat (3) @(negedge clk);
      check_idle_outputs("reset");
      rst_n = 1'b1;
      @(negedge clk);

      // All slots invalid: background plus four empty setups.
      run_frame(-1, 100, -1, aborted);

      set_slot(2, 2, 0, 1'b1);
      run_frame(-1, 100, -1, aborted);

      inst_valid = '0;
      set_slot(1, 6, 2, 1'b1);
      run_frame(-1, 100, -1, aborted);

      // Five-cycle back-pressure in the middle of the background.
      run_frame(-1, 100, 13, aborted);

      // Overrun during a sprite draw, then a clean restart.
      inst_valid = '0;
      set_slot(0, 0, 0, 1'b1);
      run_frame(SW*SH + 3, 100, -1, aborted);
      check("abort_reached", 40'(aborted), 40'd1);
      exp_ovr++;
      randomize_slots();
      run_frame(-1, 100, -1, aborted);

      for (int f = 0; f < 20; f++) begin
         randomize_slots();
         run_frame(-1, (f % 2 == 0) ? 100 : 70, -1, aborted);
      end

      // Reset in the middle of a frame.
      randomize_slots();
      frame_start = 1'b1;
      @(negedge clk);
      frame_start = 1'b0;
      repeat (10) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      check_idle_outputs("mid_reset");
      rst_n = 1'b1;
      exp_ovr = 0;
      @(negedge clk);
      check("no_done_after_reset", 40'(o_frame_done), 40'd0);
      randomize_slots();
      run_frame(-1, 80, -1, aborted);

`ifdef LAYER_SEQ_OVERRUN_CNT_EN
      frame_start = 1'b1;
      repeat (300) @(negedge clk);
      frame_start = 1'b0;
      check("overrun_saturate", 40'(o_overrun_cnt), 40'd255);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      check("overrun_reset", 40'(o_overrun_cnt), 40'd0);
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/layer_sequencer.md
Name: layer_sequencer

Overview:
- Parametrised successor of the fixed four-layer draw controller; composes one frame into VRAM.
- Draws a tiled background first, then NUM_LAYERS sprite layers of up to MAX_INST instances each, in order.
- Adds the following over the fixed controller:
  - per-instance valid mask
  - positions latched at frame start
  - screen-edge clipping
  - VRAM back-pressure (i_ready)
  - abort/restart on frame overrun
- Sits between game-state logic (positions) and the VRAM/sprite-buffer port mux.

Parameters:
- VRAM_A_WIDTH, 16, VRAM address width.
- SPRITEBUF_A_WIDTH, 14, sprite buffer address width.
- SCREEN_WIDTH, 320, screen pixels per line.
- SCREEN_HEIGHT, 180, screen lines.
- SPRITE_SIZE, 32, square sprite edge; power of two.
- NUM_LAYERS, 3, sprite layers drawn after the background.
- MAX_INST, 8, instance slots per layer.
- BG_OFFSET, 0, sprite-buffer base address of the background tile.
- LAYER_OFFSETS, 0, packed NUM_LAYERS*SPRITEBUF_A_WIDTH bits; layer k base address is at slice k.

Ports:
- CLK  in  1  clock.
- rst_n  in  1  synchronous active-low reset.
- i_frame_start  in  1  one-cycle pulse; start composing a frame.
- i_pos_x  in  10*NUM_LAYERS*MAX_INST  instance x; slot s=k*MAX_INST+i at bits [10s+9:10s].
- i_pos_y  in  10*NUM_LAYERS*MAX_INST  instance y; same packing as i_pos_x.
- i_inst_valid  in  NUM_LAYERS*MAX_INST  instance enable mask, bit s.
- i_ready  in  1  VRAM write accepted this cycle.
- o_address_screen  out  VRAM_A_WIDTH  destination pixel address.
- o_address_s  out  SPRITEBUF_A_WIDTH  source sprite pixel address.
- o_we  out  1  pixel write valid.
- o_busy  out  1  frame in progress.
- o_frame_done  out  1  one-cycle pulse after the last pixel of a frame.
- o_layer_idx  out  4  current layer (0=background, k+1=sprite layer k).
- o_inst_idx  out  4  current instance index.

Behaviour:
- Reset (rst_n=0 at a CLK edge): state IDLE; all outputs 0; latched positions and mask cleared.
- States:
  - IDLE: wait for i_frame_start, then go to BG.
  - BG: walk the full screen.
  - SETUP: examine one instance slot.
  - DRAW: walk one sprite.
  - DONE: single cycle, then IDLE.
- Frame start: i_frame_start in IDLE latches i_pos_x, i_pos_y and i_inst_valid. The first BG pixel is presented the next cycle.
- Pixel transfer: a pixel completes when o_we && i_ready. Outputs and counters hold while o_we=1 and i_ready=0. Throughput is 1 pixel/cycle at i_ready=1.
- BG pixel (x,y):
  - address_screen = y*SCREEN_WIDTH + x.
  - address_s = BG_OFFSET + (y mod SPRITE_SIZE)*SPRITE_SIZE + (x mod SPRITE_SIZE).
  - Exactly SCREEN_WIDTH*SCREEN_HEIGHT pixels, raster order.
- SETUP: one cycle per slot, visiting layer 0..NUM_LAYERS-1 and instance 0..MAX_INST-1. Valid slot -> DRAW; invalid slot -> next slot. After the last slot -> DONE.
- DRAW pixel (sx,sy), sx and sy 0..SPRITE_SIZE-1, raster order; screen position X = pos_x+sx, Y = pos_y+sy, using 11-bit sums with no wrap.
  - address_screen = Y*SCREEN_WIDTH + X.
  - address_s = LAYER_OFFSETS[k] + sy*SPRITE_SIZE + sx.
  - Clipping: if X>=SCREEN_WIDTH or Y>=SCREEN_HEIGHT, o_we=0 and the counter advances in one cycle regardless of i_ready.
  - After the last sprite pixel -> SETUP for the next slot.
- DONE: o_frame_done=1 for one cycle; o_busy=0 from the next cycle.
- o_busy=1 in every state except IDLE.
- o_we=0 in IDLE, SETUP and DONE.
- Overrun: i_frame_start while busy aborts the current frame with no o_frame_done, re-latches inputs and restarts BG the next cycle.
- Reset mid-frame: returns to IDLE immediately; no o_frame_done.
- Input changes during a frame have no effect until the next i_frame_start.

Optional Feature:
- LAYER_SEQ_OVERRUN_CNT_EN defined: adds port o_overrun_cnt (out, 8), an 8-bit saturating count of aborted frames; cleared by reset, stays at 255 once reached.
- Undefined: the port is absent and no counter logic is built.

Decomposition:
- Package layer_seq_pkg holds:
  - state enum (IDLE, BG, SETUP, DRAW, DONE)
  - localparams SLOT_NUM = NUM_LAYERS*MAX_INST and SPR_BITS = log2(SPRITE_SIZE)
  - position width (10)
- One sub-module, rect_walker:
  - parametrised width/height counter with start, advance and done.
  - Used for both the BG walk and the sprite walk.

Test Plan (SCREEN 8x4, SPRITE_SIZE 4, NUM_LAYERS 2, MAX_INST 2, BG_OFFSET 0, LAYER_OFFSETS {32,16}, i_ready=1 unless stated):
- All slots invalid, i_frame_start -> 32 BG writes, addresses screen 0..31; o_frame_done exactly 37 cycles after the start pulse (32 BG + 4 SETUP + DONE).
- BG tiling: pixel (5,1) -> address_screen 13, address_s 5.
- Layer 1 instance 0 valid at (2,0) -> 16 writes, first (address_screen 2, address_s 32), last (address_screen 29, address_s 47).
- Layer 0 instance 1 at (6,2) -> only 4 writes (screen 22,23,30,31); 12 clipped pixels with o_we=0 and no stall.
- i_ready held low for 5 cycles mid-BG -> o_address_screen and o_we frozen; no pixel skipped or duplicated.
- i_frame_start during DRAW -> no o_frame_done; BG restarts at address 0 next cycle; o_overrun_cnt=1 when the feature is enabled.
